// File: rtl/bus_sequencer_pkg.sv
// Shared definitions for the fetch/execute bus sequencer: control-word layout,
// sequencer states and instruction field encodings.
package bus_sequencer_pkg;

  localparam int CONTROL_W = 14;

  localparam int LOAD_IR     = 13;
  localparam int LOAD_PC     = 12;
  localparam int LOAD_A      = 11;
  localparam int LOAD_B      = 10;
  localparam int LOAD_X      = 9;
  localparam int DO_OUT      = 8;
  localparam int STORE_MEM   = 7;
  localparam int ASSERT_M    = 6;
  localparam int ASSERT_E    = 5;
  localparam int ASSERT_A    = 4;
  localparam int ASSERT_X    = 3;
  localparam int IMMEDIATE   = 2;
  localparam int DO_SUBTRACT = 1;
  localparam int DO_JUMP     = 0;

  typedef enum logic [1:0] {FETCH, EXEC, HALT, DMA} state_t;

  typedef enum logic [1:0] {SRC_A, SRC_X, SRC_M, SRC_E} src_t;

  typedef enum logic [2:0] {
    DST_A, DST_B, DST_X, DST_OUT, DST_MEM, DST_JMP, DST_JCC, DST_HALT
  } dst_t;

endpackage

// File: rtl/bus_sequencer_insn_decode.sv
// Combinational EXEC-phase decode of the instruction register into the control word.
// Exactly one bus driver is selected by the source field; halt and mem->mem emit nothing.
module bus_sequencer_insn_decode
  import bus_sequencer_pkg::*;
(
  input  logic [7:0]           ir,
  input  logic                 flag,
  output logic [CONTROL_W-1:0] ctrl,
  output logic                 pc_inc,
  output logic                 illegal,
  output logic                 halt
);

  src_t src;
  dst_t dst;
  logic unused_bits;

  assign src         = src_t'(ir[7:6]);
  assign dst         = dst_t'(ir[5:3]);
  assign unused_bits = ir[0];

  always_comb begin
    ctrl    = '0;
    pc_inc  = 1'b0;
    illegal = (src == SRC_M) && (dst == DST_MEM);
    halt    = (dst == DST_HALT);
    if (!illegal && !halt) begin
      case (src)
        SRC_A: ctrl[ASSERT_A] = 1'b1;
        SRC_X: ctrl[ASSERT_X] = 1'b1;
        SRC_M: begin
          ctrl[ASSERT_M] = 1'b1;
          // Immediate operand sits at PC, so the fetch pointer must advance.
          if (ir[2]) begin
            ctrl[IMMEDIATE] = 1'b1;
            pc_inc          = 1'b1;
          end
        end
        SRC_E: begin
          ctrl[ASSERT_E]    = 1'b1;
          ctrl[DO_SUBTRACT] = ir[1];
        end
        default: ;
      endcase
      case (dst)
        DST_A:   ctrl[LOAD_A]    = 1'b1;
        DST_B:   ctrl[LOAD_B]    = 1'b1;
        DST_X:   ctrl[LOAD_X]    = 1'b1;
        DST_OUT: ctrl[DO_OUT]    = 1'b1;
        DST_MEM: ctrl[STORE_MEM] = 1'b1;
        DST_JMP: begin
          ctrl[LOAD_PC] = 1'b1;
          ctrl[DO_JUMP] = 1'b1;
        end
        DST_JCC: begin
          ctrl[LOAD_PC] = flag;
          ctrl[DO_JUMP] = flag;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/bus_sequencer.sv
// Two-phase fetch/execute sequencer with HALT and instruction-boundary DMA hand-off
// of the shared data bus; counts retired instructions.
module bus_sequencer
  import bus_sequencer_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 resetB,
  input  logic [7:0]           dbus,
  input  logic                 flag,
  input  logic                 resume,
  input  logic                 dmaReq,
  output logic                 dmaGnt,
  output logic [CONTROL_W-1:0] controlBits,
  output logic                 pcInc,
  output logic                 halted,
  output logic                 illegal,
  output logic [7:0]           ir,
  output logic [CNT_W-1:0]     retired
);

  state_t state, state_next;
  logic   resume_pending, resume_pending_next;

  logic [CONTROL_W-1:0] dec_ctrl;
  logic                 dec_pc_inc;
  logic                 dec_illegal;
  logic                 dec_halt;

  bus_sequencer_insn_decode u_decode (
    .ir      (ir),
    .flag    (flag),
    .ctrl    (dec_ctrl),
    .pc_inc  (dec_pc_inc),
    .illegal (dec_illegal),
    .halt    (dec_halt)
  );

  always_ff @(posedge clk) begin
    if (!resetB) begin
      state          <= FETCH;
      resume_pending <= 1'b0;
      dmaGnt         <= 1'b0;
      ir             <= '0;
      retired        <= '0;
    end else begin
      state          <= state_next;
      resume_pending <= resume_pending_next;
      dmaGnt         <= (state_next == DMA);
      if (state == FETCH) ir <= dbus;
      if (state == EXEC)  retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // resume_pending selects the DMA exit: FETCH when set, otherwise back to HALT.
  // A grant taken at an EXEC boundary is treated as already resumed.
  always_comb begin
    state_next          = state;
    resume_pending_next = resume_pending;
    case (state)
      FETCH: state_next = EXEC;
      EXEC: begin
        if (dec_halt) begin
          state_next = HALT;
        end else if (dmaReq) begin
          state_next          = DMA;
          resume_pending_next = 1'b1;
        end else begin
          state_next = FETCH;
        end
      end
      HALT: begin
        if (dmaReq) begin
          state_next          = DMA;
          resume_pending_next = resume;
        end else if (resume) begin
          state_next = FETCH;
        end
      end
      DMA: begin
        resume_pending_next = resume_pending | resume;
        if (!dmaReq) state_next = (resume_pending | resume) ? FETCH : HALT;
      end
      default: state_next = FETCH;
    endcase
  end

  always_comb begin
    controlBits = '0;
    pcInc       = 1'b0;
    illegal     = 1'b0;
    if (resetB) begin
      case (state)
        FETCH: begin
          controlBits[LOAD_IR]   = 1'b1;
          controlBits[ASSERT_M]  = 1'b1;
          controlBits[IMMEDIATE] = 1'b1;
          pcInc                  = 1'b1;
        end
        EXEC: begin
          controlBits = dec_ctrl;
          pcInc       = dec_pc_inc;
          illegal     = dec_illegal;
        end
        default: ;
      endcase
    end
  end

  assign halted = resetB && (state == HALT);

endmodule
